// File: rtl/noc_pkg.sv
// Shared NoC router definitions: one-hot input-port grants, default flit width,
// flit type and the receive-handshake state encoding.
package noc_pkg;

    localparam int NOC_DATA_WIDTH = 32;

    localparam logic [4:0] PORT_N = 5'b00001;
    localparam logic [4:0] PORT_E = 5'b00010;
    localparam logic [4:0] PORT_W = 5'b00100;
    localparam logic [4:0] PORT_S = 5'b01000;
    localparam logic [4:0] PORT_L = 5'b10000;

    typedef logic [NOC_DATA_WIDTH-1:0] flit_t;

    // The ACK encoding is 1 so the state bit is the CTS value itself.
    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_e;

endpackage

// File: rtl/cts_handshake_rx.sv
// Receive side of the RTS/DCTS link handshake: one accept pulse and one
// CTS cycle per flit offered by upstream.
module cts_handshake_rx
    import noc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic DRTS,
    input  logic full,
    output logic CTS,
    output logic write_en
);

    hs_state_e state_q;
    hs_state_e state_d;
    logic      accept;

    // DRTS is still high during the ACK cycle; gating on IDLE blocks a repeat write.
    assign accept   = DRTS & (state_q == HS_IDLE) & ~full;
    assign write_en = accept;

    always_comb begin
        state_d = HS_IDLE;
        if (accept) begin
            state_d = HS_ACK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign CTS = (state_q == HS_ACK);

endmodule

// File: rtl/noc_input_fifo.sv
// Router input port: accepts flits over the RTS/DCTS handshake into a circular
// FIFO drained by one-hot crossbar grants. NOC_FIFO_CNT_EN adds an occupancy port.
module noc_input_fifo
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int DEPTH      = 4
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  DRTS,
    input  logic [DATA_WIDTH-1:0] Data_in,
    output logic                  CTS,
    input  logic [4:0]            read_en,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full
`ifdef NOC_FIFO_CNT_EN
    ,
    output logic [$clog2(DEPTH):0] occupancy
`endif
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic                  write_en;
    logic                  do_read;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           wr_ptr_d;
    logic [AW:0]           rd_ptr_q;
    logic [AW:0]           rd_ptr_d;

    cts_handshake_rx u_handshake (
        .clk      (clk),
        .rst      (rst),
        .DRTS     (DRTS),
        .full     (full),
        .CTS      (CTS),
        .write_en (write_en)
    );

    // Any set grant bit counts as one read; an empty FIFO ignores grants.
    assign do_read = (|read_en) & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (write_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; pointers alone define valid content.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= Data_in;
        end
    end

    assign Data_out = mem_q[rd_ptr_q[AW-1:0]];

`ifdef NOC_FIFO_CNT_EN
    logic [AW:0] count_q;
    logic [AW:0] count_d;

    always_comb begin
        count_d = count_q;
        case ({write_en, do_read})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign occupancy = count_q;
`else
    // The extra wrap bit separates full (wrap bits differ) from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
`endif

endmodule

// File: tb/tb_noc_input_fifo.sv
// Directed plus randomized bench for noc_input_fifo against a queue-based model
// of the link handshake and FIFO contents.
module tb_noc_input_fifo;
    import noc_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          DRTS    = 1'b0;
    logic [DW-1:0] Data_in = '0;
    logic [4:0]    read_en = '0;
    logic          CTS;
    logic [DW-1:0] Data_out;
    logic          empty;
    logic          full;
`ifdef NOC_FIFO_CNT_EN
    logic [$clog2(DEPTH):0] occupancy;
`endif

    always #5 clk = ~clk;

    noc_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .DRTS     (DRTS),
        .Data_in  (Data_in),
        .CTS      (CTS),
        .read_en  (read_en),
        .Data_out (Data_out),
        .empty    (empty),
        .full     (full)
`ifdef NOC_FIFO_CNT_EN
        ,
        .occupancy(occupancy)
`endif
    );

    logic [DW-1:0] exp_q[$];
    bit            cts_m;
    int            vectors;
    int            miscompares;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_cts"},   32'(CTS),   32'(cts_m));
        check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check({tag, "_full"},  32'(full),  32'(exp_q.size() == DEPTH));
`ifdef NOC_FIFO_CNT_EN
        check({tag, "_occ"},   32'(occupancy), 32'(exp_q.size()));
`endif
        if (exp_q.size() != 0) begin
            check({tag, "_data"}, Data_out, exp_q[0]);
        end
    endtask

    // Model update uses pre-edge inputs; DUT outputs are sampled 1 ns after the edge.
    task automatic step();
        bit acc;
        bit rd;
        if (!rst) begin
            exp_q.delete();
            cts_m = 1'b0;
        end else begin
            acc = DRTS && !cts_m && (exp_q.size() < DEPTH);
            rd  = (read_en != 5'b0) && (exp_q.size() != 0);
            if (rd) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(Data_in);
            cts_m = acc;
        end
        @(posedge clk);
        #1;
        check_outputs("step");
    endtask

    task automatic send_flit(input logic [DW-1:0] data);
        bit got;
        got     = 1'b0;
        DRTS    = 1'b1;
        Data_in = data;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = cts_m;
        end
        vectors++;
        assert (got) else begin
            miscompares++;
            $error("FAIL send_timeout: observed no accept expected accept for %0h", data);
        end
        step();
        DRTS    = 1'b0;
        Data_in = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            read_en = 5'($urandom_range(1, 31));
            step();
        end
        read_en = '0;
    endtask

    function automatic logic [4:0] rand_onehot();
        logic [4:0] ports [5];
        ports[0] = PORT_N; ports[1] = PORT_E; ports[2] = PORT_W;
        ports[3] = PORT_S; ports[4] = PORT_L;
        return ports[$urandom_range(0, 4)];
    endfunction

    initial begin
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        bit            was_ack;

        // Reset held with DRTS high
        DRTS    = 1'b1;
        Data_in = $urandom;
        #1;
        check_outputs("reset");
        repeat (3) step();
        rst = 1'b1;
        step();
        check("rst_release_cts", 32'(CTS), 32'd1);
        step();
        check("rst_release_cts_low", 32'(CTS), 32'd0);
        DRTS = 1'b0;
        step();
        drain();

        // Single flit
        send_flit(32'hA5A5_0001);
        check("single_data", Data_out, 32'hA5A5_0001);
        check("single_empty", 32'(empty), 32'd0);
        read_en = 5'b00100;
        step();
        read_en = '0;
        check("single_drained", 32'(empty), 32'd1);

        // Fill, then a fifth request held off while full
        for (int i = 0; i < DEPTH; i++) send_flit($urandom);
        check("fill_full", 32'(full), 32'd1);
        DRTS    = 1'b1;
        Data_in = 32'hF1F0_0005;
        repeat (10) begin
            step();
            check("full_hold_cts", 32'(CTS), 32'd0);
        end
        read_en = PORT_N;
        step();
        read_en = '0;
        check("full_read_no_cts", 32'(CTS), 32'd0);
        step();
        check("fifth_accept_cts", 32'(CTS), 32'd1);
        check("fifth_refull", 32'(full), 32'd1);
        step();
        DRTS = 1'b0;
        drain();

        // Ten sequential flits across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            send_flit(DW'(i));
            check("wrap_head", Data_out, DW'(i));
            read_en = rand_onehot();
            step();
            read_en = '0;
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // Simultaneous read and write at count 2
        a = $urandom;
        b = $urandom;
        send_flit(a);
        send_flit(b);
        DRTS    = 1'b1;
        Data_in = $urandom;
        read_en = PORT_S;
        step();
        read_en = '0;
        check("simul_cts", 32'(CTS), 32'd1);
        check("simul_head", Data_out, b);
`ifdef NOC_FIFO_CNT_EN
        check("simul_occ", 32'(occupancy), 32'd2);
`endif
        step();
        DRTS = 1'b0;
        drain();

        // Randomized traffic with a protocol-following upstream
        for (int i = 0; i < 400; i++) begin
            read_en = ($urandom_range(0, 1) == 0) ? 5'b0 : 5'($urandom_range(1, 31));
            was_ack = cts_m;
            step();
            if (DRTS && was_ack) begin
                DRTS = 1'b0;
            end else if (!DRTS && $urandom_range(0, 2) != 0) begin
                DRTS    = 1'b1;
                Data_in = $urandom;
            end
        end
        read_en = '0;
        if (DRTS) begin
            was_ack = cts_m;
            step();
            if (!was_ack) step();
            step();
            DRTS = 1'b0;
        end
        drain();

        // Reset asserted during the ACK cycle
        send_flit($urandom);
        send_flit($urandom);
        DRTS    = 1'b1;
        Data_in = $urandom;
        step();
        check("midack_cts_high", 32'(CTS), 32'd1);
        rst = 1'b0;
        #1;
        exp_q.delete();
        cts_m = 1'b0;
        check_outputs("midack_async");
        DRTS = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        read_en = PORT_L;
        step();
        read_en = '0;
        check("midack_lost", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
